// File: rtl/tile_reader.sv
// tile_reader: walks an inclusive, wrapping range of SRAM word addresses,
// issuing one read per cycle to a 1-cycle-latency SRAM, and forwards each
// returned word with its address and a valid strobe to the row router.
// Reading ends at the end address or early when the routers report empty.
module tile_reader #(
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic                       i_reg_clear,
  input  logic                       i_start,
  input  logic [ADDR_WIDTH-1:0]      i_start_addr,
  input  logic [ADDR_WIDTH-1:0]      i_end_addr,
  input  logic                       i_hold,
  input  logic                       i_route_done,
  output logic                       o_sram_rd_en,
  output logic [ADDR_WIDTH-1:0]      o_sram_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] i_sram_rdata,
  output logic [SRAM_DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0]      o_addr,
  output logic                       o_data_valid,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [ADDR_WIDTH:0]        o_word_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                     state_q;
  logic [ADDR_WIDTH-1:0]      cur_addr_q;
  logic [ADDR_WIDTH-1:0]      end_addr_q;
  logic                       done_q;

  logic                       valid_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [SRAM_DATA_WIDTH-1:0] data_hold_q;
  logic [ADDR_WIDTH:0]        count_q;

  logic                       rd_en;
  logic                       start_acc;

  // Read request: issued every READ cycle unless stalled or routers are satisfied.
  always_comb begin
    rd_en     = (state_q == S_READ) && !i_hold && !i_route_done;
    start_acc = (state_q == S_IDLE) && i_start;
  end

  // Control FSM: address walk, range latch and completion pulse.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      end_addr_q <= '0;
      done_q     <= 1'b0;
    end else if (i_reg_clear) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      end_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      // The done pulse trails the DONE state by one register stage.
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            cur_addr_q <= i_start_addr;
            end_addr_q <= i_end_addr;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          if (i_route_done) begin
            state_q <= S_DRAIN;
          end else if (!i_hold) begin
            if (cur_addr_q == end_addr_q) begin
              state_q <= S_DRAIN;
            end else begin
              cur_addr_q <= cur_addr_q + 1'b1;
            end
          end
        end
        S_DRAIN: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Return path: valid/address registered alongside the SRAM latency; word counter.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      valid_q     <= 1'b0;
      addr_q      <= '0;
      data_hold_q <= '0;
      count_q     <= '0;
    end else if (i_reg_clear) begin
      valid_q     <= 1'b0;
      addr_q      <= '0;
      data_hold_q <= '0;
      count_q     <= '0;
    end else begin
      valid_q <= rd_en;
      if (rd_en) begin
        addr_q <= cur_addr_q;
      end
      if (valid_q) begin
        data_hold_q <= i_sram_rdata;
      end
      if (start_acc) begin
        count_q <= '0;
      end else if (valid_q) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // SRAM data arrives in the valid cycle itself, so it bypasses the hold
  // register then; the hold register only keeps o_data stable between words.
  always_comb begin
    o_data = valid_q ? i_sram_rdata : data_hold_q;
  end

  assign o_sram_rd_en = rd_en;
  assign o_sram_addr  = cur_addr_q;
  assign o_addr       = addr_q;
  assign o_data_valid = valid_q;
  assign o_busy       = (state_q == S_READ) || (state_q == S_DRAIN);
  assign o_done       = done_q;
  assign o_word_count = count_q;

endmodule

// File: tb/tb_tile_reader.sv
// Testbench for tile_reader: directed and randomized address walks checked
// against a transaction-level expectation of issued/delivered addresses,
// data, completion timing and word count.
module tb_tile_reader;

  localparam int DW = 64;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          nrst;
  logic          clear;
  logic          start;
  logic [AW-1:0] sa;
  logic [AW-1:0] ea;
  logic          hold;
  logic          route;
  logic          rd_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] rdata;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;
  logic          valid;
  logic          busy;
  logic          done;
  logic [AW:0]   count;

  logic [DW-1:0] mem [256];

  int checks = 0;
  int errors = 0;

  tile_reader #(
    .SRAM_DATA_WIDTH(DW),
    .ADDR_WIDTH     (AW)
  ) dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_reg_clear (clear),
    .i_start     (start),
    .i_start_addr(sa),
    .i_end_addr  (ea),
    .i_hold      (hold),
    .i_route_done(route),
    .o_sram_rd_en(rd_en),
    .o_sram_addr (sram_addr),
    .i_sram_rdata(rdata),
    .o_data      (data),
    .o_addr      (addr),
    .o_data_valid(valid),
    .o_busy      (busy),
    .o_done      (done),
    .o_word_count(count)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency SRAM; garbage on the bus when no read was issued.
  always @(posedge clk) begin
    rdata <= rd_en ? mem[sram_addr] : {$urandom, $urandom};
  end

  task automatic test_reset();
    nrst = 1'b0; clear = 1'b0; start = 1'b0; sa = '0; ea = '0; hold = 1'b0; route = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rd_en, sram_addr, data, addr, valid, busy, done, count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd_en=%b sram_addr=%h data=%h addr=%h valid=%b busy=%b done=%b count=%0d, want all zero",
               rd_en, sram_addr, data, addr, valid, busy, done, count);
    end
    @(posedge clk); #1 nrst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_en, valid, busy, done, count} !== '0) begin
      errors++;
      $display("FAIL reset_idle: rd_en=%b valid=%b busy=%b done=%b count=%0d, want all zero",
               rd_en, valid, busy, done, count);
    end
  endtask

  // One transfer: k = routers satisfied after k reads (-1 = never);
  // hold asserted on cycles [hs, hs+hl); tail = extra cycles watched after done.
  task automatic test_transfer(input string name, input logic [AW-1:0] s, input logic [AW-1:0] e,
                               input int hs, input int hl, input int k, input int tail);
    int total, n, exp_done, rd_cnt, done_cnt, done_at, busy_bad, seq_bad;
    bit early, prev_rd, bad_i, bad_d;
    logic [AW-1:0] prev_addr, ea_exp;
    logic [AW-1:0] iss [$];
    logic [AW-1:0] dla [$];
    logic [DW-1:0] dld [$];

    total    = int'(8'(e - s)) + 1;
    early    = (k >= 0) && (k < total);
    n        = early ? k : total;
    exp_done = n + 3 + hl + (early ? 1 : 0);
    rd_cnt = 0; done_cnt = 0; done_at = -1; busy_bad = 0; seq_bad = 0;
    prev_rd = 1'b0; prev_addr = '0;

    @(posedge clk); #1;
    start = 1'b1; sa = s; ea = e; hold = 1'b0; route = (k == 0);
    for (int cyc = 1; cyc <= exp_done + tail; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      hold  = (cyc >= hs) && (cyc < hs + hl);
      if (k >= 0 && rd_cnt >= k) route = 1'b1;
      @(negedge clk);
      if (valid) begin
        dla.push_back(addr);
        dld.push_back(data);
        if (!prev_rd || addr !== prev_addr) seq_bad++;
      end else if (prev_rd) begin
        seq_bad++;
      end
      if (rd_en) begin
        iss.push_back(sram_addr);
        rd_cnt++;
      end
      prev_rd   = rd_en;
      prev_addr = sram_addr;
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (busy !== (cyc <= exp_done - 2)) busy_bad++;
    end
    route = 1'b0;
    hold  = 1'b0;

    bad_i = (iss.size() != n);
    for (int i = 0; i < iss.size() && i < n; i++) begin
      ea_exp = 8'(s + i);
      if (iss[i] !== ea_exp) bad_i = 1'b1;
    end
    checks++;
    if (bad_i) begin
      errors++;
      $display("FAIL %s issued_addrs: got %0d reads (first %h), want %0d reads from %h",
               name, iss.size(), (iss.size() > 0) ? iss[0] : 8'h00, n, s);
    end

    bad_d = (dla.size() != n);
    for (int i = 0; i < dla.size() && i < n; i++) begin
      ea_exp = 8'(s + i);
      if (dla[i] !== ea_exp || dld[i] !== mem[ea_exp]) bad_d = 1'b1;
    end
    checks++;
    if (bad_d) begin
      errors++;
      $display("FAIL %s delivered_words: got %0d words, want %0d in address order with matching data",
               name, dla.size(), n);
    end

    checks++;
    if (seq_bad != 0) begin
      errors++;
      $display("FAIL %s valid_latency: %0d cycles where valid/addr did not follow the previous read, want 0",
               name, seq_bad);
    end

    checks++;
    if (done_cnt != 1 || done_at != exp_done) begin
      errors++;
      $display("FAIL %s done_pulse: got %0d pulses last at cycle %0d, want 1 at cycle %0d",
               name, done_cnt, done_at, exp_done);
    end

    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy: %0d wrong cycles, want high exactly on cycles 1..%0d",
               name, busy_bad, exp_done - 2);
    end

    checks++;
    if (count !== 9'(n)) begin
      errors++;
      $display("FAIL %s word_count: got %0d want %0d", name, count, n);
    end
  endtask

  task automatic test_directed();
    test_transfer("basic",      8'h10, 8'h13, 0, 0, -1, 3);
    test_transfer("wrap",       8'hFE, 8'h01, 0, 0, -1, 3);
    test_transfer("single",     8'h05, 8'h05, 0, 0, -1, 3);
    test_transfer("hold",       8'h00, 8'h07, 3, 2, -1, 3);
    test_transfer("route_done", 8'h00, 8'h0F, 0, 0, 5, 3);
    test_transfer("route_init", 8'h30, 8'h37, 0, 0, 0, 3);
    test_transfer("full_range", 8'h80, 8'h7F, 0, 0, -1, 3);
  endtask

  task automatic test_back_to_back();
    test_transfer("b2b_first",  8'h40, 8'h41, 0, 0, -1, 0);
    test_transfer("b2b_second", 8'hC0, 8'hC2, 0, 0, -1, 0);
    test_transfer("b2b_third",  8'h07, 8'h07, 0, 0, -1, 3);
  endtask

  // Abort a run after a few reads, by synchronous clear or by asynchronous reset.
  task automatic test_abort(input bit use_nrst);
    string nm;
    int stray;
    nm = use_nrst ? "abort_nrst" : "abort_clear";
    @(posedge clk); #1 start = 1'b1; sa = 8'h20; ea = 8'h3F;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (use_nrst) nrst = 1'b0;
    else          clear = 1'b1;
    @(posedge clk); #1 nrst = 1'b1; clear = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_en, sram_addr, data, addr, valid, busy, done, count} !== '0) begin
      errors++;
      $display("FAIL %s outputs: rd_en=%b sram_addr=%h data=%h addr=%h valid=%b busy=%b done=%b count=%0d, want all zero",
               nm, rd_en, sram_addr, data, addr, valid, busy, done, count);
    end
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (rd_en || valid || busy || done) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL %s quiet_after: %0d cycles with activity, want 0", nm, stray);
    end
    test_transfer(use_nrst ? "after_nrst" : "after_clear", 8'h50, 8'h55, 0, 0, -1, 3);
  endtask

  task automatic test_random();
    logic [AW-1:0] s, e;
    int total, mode, hs, hl, k;
    for (int it = 0; it < 20; it++) begin
      s     = 8'($urandom);
      e     = 8'(s + $urandom_range(0, 40));
      total = int'(8'(e - s)) + 1;
      mode  = $urandom_range(0, 2);
      hs = 0; hl = 0; k = -1;
      if (mode == 1) begin
        hs = $urandom_range(1, total);
        hl = $urandom_range(1, 3);
      end else if (mode == 2) begin
        k = $urandom_range(0, total);
      end
      test_transfer($sformatf("rand%0d", it), s, e, hs, hl, k, $urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    test_reset();
    test_directed();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    test_random();
    $display("test done: total=%0d bad=%0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
